// File: rtl/idma_init_pkg.sv
// Shared types and constants for the iDMA INIT pattern sources.
// Mode encoding, LFSR taps and default-width request/response bundles.
package idma_init_pkg;

  typedef enum logic [1:0] {
    INIT_CONST = 2'd0,
    INIT_INCR  = 2'd1,
    INIT_LFSR  = 2'd2,
    INIT_ZERO  = 2'd3
  } init_mode_e;

  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  localparam int unsigned DefStrbWidth = 16;
  localparam int unsigned DefLenWidth  = 16;
  localparam int unsigned DefDataWidth = 8 * DefStrbWidth;

  typedef struct packed {
    init_mode_e                mode;
    logic [DefDataWidth-1:0]   seed;
    logic [DefLenWidth-1:0]    len;
  } init_req_t;

  typedef struct packed {
    logic [DefDataWidth-1:0]   data;
    logic                      last;
  } init_rsp_t;

  // An all-zero Galois state never leaves zero, so it is replaced by 1.
  function automatic logic [31:0] lfsr_seed(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/idma_init_lfsr.sv
// 32-bit right-shifting Galois LFSR step.
// Shared by the INIT generator and other test-pattern sources.
module idma_init_lfsr
  import idma_init_pkg::*;
(
  input  logic [31:0] state_i,
  input  logic        en_i,
  output logic [31:0] state_o
);

  logic [31:0] w_next;

  assign w_next  = {1'b0, state_i[31:1]}
                 ^ (state_i[0] ? LfsrTaps : 32'h0);
  assign state_o = en_i ? w_next : state_i;

endmodule

// File: rtl/idma_init_pattern_gen.sv
// iDMA INIT subordinate: one request in, a burst of generated beats out.
// Supports constant, incrementing-byte, LFSR and zero fill patterns.
module idma_init_pattern_gen
  import idma_init_pkg::*;
#(
  parameter  int unsigned StrbWidth = 16,
  parameter  int unsigned LenWidth  = 16,
  localparam int unsigned DataWidth = 8 * StrbWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [1:0]           req_mode_i,
  input  logic [DataWidth-1:0] req_seed_i,
  input  logic [LenWidth-1:0]  req_len_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_data_o,
  output logic                 rsp_last_o,
  output logic                 busy_o
);

  if ((StrbWidth % 4) != 0) begin : g_strb_chk
    $error("StrbWidth must be a multiple of 4");
  end

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_e;

  state_e               r_state;
  init_mode_e           r_mode;
  logic [DataWidth-1:0] r_seed;
  logic [LenWidth-1:0]  r_len;
  logic [LenWidth-1:0]  r_cnt;
  logic [7:0]           r_base;
  logic [31:0]          r_lfsr;

  logic                 w_stream;
  logic                 w_last;
  logic                 w_req_hs;
  logic                 w_rsp_hs;
  logic [31:0]          w_lfsr_nxt;
  logic [DataWidth-1:0] w_data;

  assign w_stream = (r_state == S_STREAM);
  assign w_last   = (r_cnt == r_len);
  assign w_rsp_hs = w_stream & rsp_ready_i;

  // A new request may chain onto the final beat's handshake.
  assign req_ready_o = ~w_stream
                     | (rsp_ready_i & w_last);
  assign w_req_hs    = req_valid_i & req_ready_o;

  idma_init_lfsr u_lfsr (
    .state_i (r_lfsr),
    .en_i    (w_rsp_hs),
    .state_o (w_lfsr_nxt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_mode  <= INIT_CONST;
      r_seed  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_base  <= '0;
      r_lfsr  <= '0;
    end else if (w_req_hs) begin
      r_state <= S_STREAM;
      r_mode  <= init_mode_e'(req_mode_i);
      r_seed  <= req_seed_i;
      r_len   <= req_len_i;
      r_cnt   <= '0;
      r_base  <= req_seed_i[7:0];
      r_lfsr  <= lfsr_seed(req_seed_i[31:0]);
    end else if (w_rsp_hs) begin
      if (w_last) begin
        r_state <= S_IDLE;
      end else begin
        r_cnt  <= r_cnt + LenWidth'(1);
        r_base <= r_base + 8'(StrbWidth);
        r_lfsr <= w_lfsr_nxt;
      end
    end
  end

  always_comb begin
    w_data = '0;
    if (w_stream) begin
      unique case (r_mode)
        INIT_CONST: w_data = r_seed;
        INIT_INCR: begin
          for (int k = 0; k < int'(StrbWidth); k++) begin
            w_data[8*k +: 8] = r_base + 8'(k);
          end
        end
        INIT_LFSR:  w_data = {(DataWidth/32){r_lfsr}};
        INIT_ZERO:  w_data = '0;
        default:    w_data = '0;
      endcase
    end
  end

  assign rsp_valid_o = w_stream;
  assign busy_o      = w_stream;
  assign rsp_last_o  = w_stream & w_last;
  assign rsp_data_o  = w_data;

endmodule

// File: tb/tb_idma_init_pattern_gen.sv
// Directed self-checking bench for idma_init_pattern_gen.
// Default widths: 16 bytes per beat, 16-bit length field.
module tb_idma_init_pattern_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_mode;
  logic [127:0] req_seed;
  logic [15:0]  req_len;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_last;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  idma_init_pattern_gen dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_mode_i  (req_mode),
    .req_seed_i  (req_seed),
    .req_len_i   (req_len),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_last_o  (rsp_last),
    .busy_o      (busy)
  );

  function automatic logic [127:0] incr_beat(
    input logic [7:0] s, input int b);
    logic [127:0] v;
    for (int k = 0; k < 16; k++)
      v[8*k +: 8] = 8'((int'(s) + b*16 + k) % 256);
    return v;
  endfunction

  // Present one request for one cycle; returns with beat 0 visible.
  task automatic start_req(input logic [1:0] m,
                           input logic [127:0] s,
                           input logic [15:0] l);
    @(negedge clk);
    req_valid = 1'b1;
    req_mode  = m;
    req_seed  = s;
    req_len   = l;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 ||
        req_ready !== 1'b1 || rsp_last !== 1'b0 ||
        rsp_data !== 128'h0) begin
      n_fail++;
      $display("FAIL reset v=%b b=%b rr=%b l=%b d=%h exp 0 0 1 0 0",
               rsp_valid, busy, req_ready, rsp_last, rsp_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_const();
    logic [127:0] exp_d;
    exp_d = {16{8'hA5}};
    rsp_ready = 1'b1;
    start_req(2'd0, exp_d, 16'd3);
    req_mode = 2'd3;
    req_seed = '1;
    req_len  = 16'd0;
    for (int b = 0; b < 4; b++) begin
      n_tests++;
      if (rsp_valid !== 1'b1 || busy !== 1'b1 ||
          rsp_data !== exp_d ||
          rsp_last !== (b == 3)) begin
        n_fail++;
        $display("FAIL const_beat%0d v=%b b=%b d=%h l=%b exp d=%h l=%b",
                 b, rsp_valid, busy, rsp_data, rsp_last,
                 exp_d, (b == 3));
      end
      if (b == 3) begin
        n_tests++;
        if (req_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL const_ready_last got=%b exp=1", req_ready);
        end
      end
      @(negedge clk);
    end
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL const_idle v=%b rr=%b b=%b exp 0 1 0",
               rsp_valid, req_ready, busy);
    end
  endtask

  task automatic test_incr();
    logic [127:0] e0, e1;
    e0 = 128'h07060504030201_00FFFEFDFCFBFAF9F8;
    e1 = 128'h17161514131211100F0E0D0C0B0A0908;
    rsp_ready = 1'b1;
    start_req(2'd1, 128'h00F8, 16'd1);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== e0 || rsp_last !== 1'b0) begin
      n_fail++;
      $display("FAIL incr_beat0 v=%b d=%h l=%b exp d=%h l=0",
               rsp_valid, rsp_data, rsp_last, e0);
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== e1 || rsp_last !== 1'b1) begin
      n_fail++;
      $display("FAIL incr_beat1 v=%b d=%h l=%b exp d=%h l=1",
               rsp_valid, rsp_data, rsp_last, e1);
    end
    @(negedge clk);
  endtask

  task automatic test_lfsr();
    logic [127:0] e0, e1;
    e0 = {4{32'h0000_0001}};
    e1 = {4{32'h8020_0003}};
    rsp_ready = 1'b1;
    start_req(2'd2, 128'h0, 16'd1);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== e0) begin
      n_fail++;
      $display("FAIL lfsr_beat0 v=%b d=%h exp=%h", rsp_valid, rsp_data, e0);
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== e1 || rsp_last !== 1'b1) begin
      n_fail++;
      $display("FAIL lfsr_beat1 v=%b d=%h l=%b exp d=%h l=1",
               rsp_valid, rsp_data, rsp_last, e1);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    int           b;
    int           cyc;
    logic         held;
    logic         rdy;
    logic [127:0] hd;
    logic         hl;
    b = 0; cyc = 0; held = 1'b0; hd = '0; hl = 1'b0;
    rsp_ready = 1'b0;
    start_req(2'd1, 128'h33, 16'd7);
    while (b < 8 && cyc < 400) begin
      if (held) begin
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== hd || rsp_last !== hl) begin
          n_fail++;
          $display("FAIL stall_hold v=%b d=%h l=%b exp d=%h l=%b",
                   rsp_valid, rsp_data, rsp_last, hd, hl);
        end
      end
      rdy = 1'($urandom_range(0, 1));
      rsp_ready = rdy;
      if (rsp_valid === 1'b1) begin
        if (rdy) begin
          n_tests++;
          if (rsp_data !== incr_beat(8'h33, b) ||
              rsp_last !== (b == 7)) begin
            n_fail++;
            $display("FAIL stall_beat%0d d=%h l=%b exp d=%h l=%b",
                     b, rsp_data, rsp_last, incr_beat(8'h33, b), (b == 7));
          end
          b++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd = rsp_data;
          hl = rsp_last;
        end
      end
      @(negedge clk);
      cyc++;
    end
    rsp_ready = 1'b1;
    n_tests++;
    if (b != 8 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_count beats=%0d v=%b exp 8 beats v=0",
               b, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] cs;
    cs = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_mode  = 2'd0;
    req_seed  = cs;
    req_len   = 16'd0;
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== cs ||
        rsp_last !== 1'b1 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_beat1 v=%b d=%h l=%b rr=%b exp d=%h l=1 rr=1",
               rsp_valid, rsp_data, rsp_last, req_ready, cs);
    end
    req_mode = 2'd3;
    req_len  = 16'd1;
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== 128'h0 ||
        rsp_last !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_beat2 v=%b d=%h l=%b rr=%b exp v=1 d=0 l=0 rr=0",
               rsp_valid, rsp_data, rsp_last, req_ready);
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== 128'h0 || rsp_last !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_beat3 v=%b d=%h l=%b exp v=1 d=0 l=1",
               rsp_valid, rsp_data, rsp_last);
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle v=%b rr=%b exp 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    start_req(2'd1, 128'h0, 16'd5);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 ||
        rsp_last !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_state v=%b b=%b rr=%b l=%b exp 0 0 1 0",
               rsp_valid, busy, req_ready, rsp_last);
    end
    rst = 1'b0;
    start_req(2'd1, 128'h40, 16'd1);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== incr_beat(8'h40, 0) ||
        rsp_last !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_new0 v=%b d=%h l=%b exp d=%h l=0",
               rsp_valid, rsp_data, rsp_last, incr_beat(8'h40, 0));
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== incr_beat(8'h40, 1) ||
        rsp_last !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_new1 v=%b d=%h l=%b exp d=%h l=1",
               rsp_valid, rsp_data, rsp_last, incr_beat(8'h40, 1));
    end
    @(negedge clk);
  endtask

  task automatic test_max_len();
    int errs;
    int first_bad;
    errs = 0;
    first_bad = -1;
    rsp_ready = 1'b1;
    start_req(2'd3, 128'h0, 16'hFFFF);
    for (int b = 0; b < 65536; b++) begin
      if (rsp_valid !== 1'b1 || rsp_last !== (b == 65535)) begin
        if (first_bad < 0) first_bad = b;
        errs++;
      end
      @(negedge clk);
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL maxlen_beats bad=%0d first=%0d exp bad=0",
               errs, first_bad);
    end
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL maxlen_end v=%b exp 0", rsp_valid);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_mode  = 2'd0;
    req_seed  = '0;
    req_len   = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_const();
    test_incr();
    test_lfsr();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_max_len();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
